// File: rtl/multicycle_logic_unit.sv
// Slice-serial bitwise logic unit (AND/OR/XOR/NOR), SLICE bits per clock, LSB slice first,
// with a start/busy/ready handshake shared with the mult/div units.
module multicycle_logic_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SLICE = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_start,
   input  logic [1:0]       ctrl_op,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic             data_resultRDY,
   output logic             data_busy,
   output logic             data_zero
);

   localparam int unsigned NSLICE = (SLICE == 0) ? 1 : WIDTH / SLICE;
   localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam int unsigned TOP    = WIDTH - SLICE;

   generate
      if (SLICE == 0 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_bad_param
         $error("multicycle_logic_unit: WIDTH must be a non-zero multiple of SLICE");
      end
   endgenerate

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [1:0]       r_op;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_result;
   logic             r_rdy;
   logic             r_busy;
   logic             r_zero;

   logic [SLICE-1:0] w_slc;
   logic [WIDTH-1:0] w_acc_next;
   logic             w_last;

   // Latched operands shift right so the active slice always sits at bit 0;
   // each result slice enters the accumulator from the top and ends in its own position.
   always_comb begin
      w_slc = '0;
      case (r_op)
         2'b00:   w_slc = r_a[SLICE-1:0] & r_b[SLICE-1:0];
         2'b01:   w_slc = r_a[SLICE-1:0] | r_b[SLICE-1:0];
         2'b10:   w_slc = r_a[SLICE-1:0] ^ r_b[SLICE-1:0];
         default: w_slc = ~(r_a[SLICE-1:0] | r_b[SLICE-1:0]);
      endcase
      w_acc_next = (r_acc >> SLICE) | (WIDTH'(w_slc) << TOP);
      w_last     = (r_cnt == CW'(NSLICE - 1));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_op     <= '0;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_result <= '0;
         r_rdy    <= 1'b0;
         r_busy   <= 1'b0;
         r_zero   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_rdy <= 1'b0;
               if (ctrl_start) begin
                  r_a     <= data_operandA;
                  r_b     <= data_operandB;
                  r_op    <= ctrl_op;
                  r_cnt   <= '0;
                  r_acc   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_a   <= r_a >> SLICE;
               r_b   <= r_b >> SLICE;
               r_acc <= w_acc_next;
               r_cnt <= r_cnt + CW'(1);
               if (w_last) begin
                  r_result <= w_acc_next;
                  r_zero   <= (w_acc_next == '0);
                  r_rdy    <= 1'b1;
                  r_busy   <= 1'b0;
                  r_state  <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign data_result    = r_result;
   assign data_resultRDY = r_rdy;
   assign data_busy      = r_busy;
   assign data_zero      = r_zero;

endmodule

// File: tb/tb_multicycle_logic_unit.sv
// Directed bench for multicycle_logic_unit: default 32/8 instance plus 16/16 and 64/4 sweeps.
module tb_multicycle_logic_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        ctrl_start;
   logic [1:0]  ctrl_op;
   logic [31:0] opa, opb;
   logic [31:0] data_result;
   logic        data_resultRDY, data_busy, data_zero;

   logic        start16, rdy16, busy16, zero16;
   logic [15:0] a16, b16, res16;
   logic        start64, rdy64, busy64, zero64;
   logic [1:0]  op64;
   logic [63:0] a64, b64, res64;

   int n_cmp  = 0;
   int n_fail = 0;
   int edges, busy_cyc, rdy_cnt;
   logic [31:0] cap;

   always #5 clock = ~clock;

   multicycle_logic_unit u_dut (
      .clock(clock), .reset(reset), .ctrl_start(ctrl_start), .ctrl_op(ctrl_op),
      .data_operandA(opa), .data_operandB(opb), .data_result(data_result),
      .data_resultRDY(data_resultRDY), .data_busy(data_busy), .data_zero(data_zero)
   );

   multicycle_logic_unit #(.WIDTH(16), .SLICE(16)) u_w16 (
      .clock(clock), .reset(reset), .ctrl_start(start16), .ctrl_op(2'b10),
      .data_operandA(a16), .data_operandB(b16), .data_result(res16),
      .data_resultRDY(rdy16), .data_busy(busy16), .data_zero(zero16)
   );

   multicycle_logic_unit #(.WIDTH(64), .SLICE(4)) u_w64 (
      .clock(clock), .reset(reset), .ctrl_start(start64), .ctrl_op(op64),
      .data_operandA(a64), .data_operandB(b64), .data_result(res64),
      .data_resultRDY(rdy64), .data_busy(busy64), .data_zero(zero64)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one op on the default instance at the current falling edge and wait for RDY.
   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit hold, input bit scramble);
      ctrl_start = 1'b1;
      ctrl_op    = op;
      opa        = a;
      opb        = b;
      edges      = 0;
      busy_cyc   = 0;
      while (edges < 40) begin
         @(negedge clock);
         edges++;
         if (edges == 1) begin
            if (!hold) ctrl_start = 1'b0;
            if (scramble) begin
               opa     = ~a;
               opb     = 32'h0;
               ctrl_op = 2'b11;
            end
         end
         if (data_busy) busy_cyc++;
         if (data_resultRDY) break;
      end
   endtask

   initial begin
      reset = 1'b1; ctrl_start = 1'b0; ctrl_op = 2'b00; opa = '0; opb = '0;
      start16 = 1'b0; a16 = '0; b16 = '0;
      start64 = 1'b0; op64 = 2'b10; a64 = '0; b64 = '0;
      repeat (2) @(negedge clock);
      chk("rst_result", data_result, 32'h0);
      chk("rst_rdy", data_resultRDY, 1'b0);
      chk("rst_busy", data_busy, 1'b0);
      chk("rst_zero", data_zero, 1'b0);
      reset = 1'b0;
      @(negedge clock);

      // Basic AND latency and busy window
      do_op(2'b00, 32'hF0F0_1234, 32'hFF00_FFFF, 1'b0, 1'b0);
      chk("and_edges", edges, 5);
      chk("and_busy", busy_cyc, 4);
      chk("and_result", data_result, 32'hF000_1234);
      chk("and_zero", data_zero, 1'b0);
      @(negedge clock);
      chk("and_rdy_pulse", data_resultRDY, 1'b0);
      chk("and_hold", data_result, 32'hF000_1234);

      // Four ops back-to-back with start held high
      do_op(2'b00, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0);
      chk("b2b_and_edges", edges, 5);
      chk("b2b_and", data_result, 32'h0);
      chk("b2b_and_zero", data_zero, 1'b1);
      do_op(2'b01, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0);
      chk("b2b_or_edges", edges, 5);
      chk("b2b_or", data_result, 32'hFFFF_FFFF);
      chk("b2b_or_zero", data_zero, 1'b0);
      do_op(2'b10, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0);
      chk("b2b_xor_edges", edges, 5);
      chk("b2b_xor", data_result, 32'hFFFF_FFFF);
      do_op(2'b11, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0);
      ctrl_start = 1'b0;
      chk("b2b_nor_edges", edges, 5);
      chk("b2b_nor", data_result, 32'h0);
      chk("b2b_nor_zero", data_zero, 1'b1);
      @(negedge clock);

      // Start pulse while busy must be ignored
      ctrl_start = 1'b1; ctrl_op = 2'b00; opa = 32'hFFFF_FFFF; opb = 32'hFFFF_FFFF;
      busy_cyc = 0; rdy_cnt = 0; cap = '0;
      for (int i = 1; i <= 15; i++) begin
         @(negedge clock);
         if (data_busy) busy_cyc++;
         if (data_resultRDY) begin
            rdy_cnt++;
            cap = data_result;
         end
         if (i == 1) ctrl_start = 1'b0;
         if (i == 2) begin
            ctrl_start = 1'b1; ctrl_op = 2'b01; opa = 32'h0; opb = 32'h0;
         end
         if (i == 3) ctrl_start = 1'b0;
      end
      chk("rej_rdy_count", rdy_cnt, 1);
      chk("rej_busy", busy_cyc, 4);
      chk("rej_result", cap, 32'hFFFF_FFFF);

      // Operand and op changes after acceptance have no effect
      do_op(2'b10, 32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b1);
      chk("chg_edges", edges, 5);
      chk("chg_result", data_result, 32'h1D3B_5977);
      @(negedge clock);

      // Reset at acceptance edge + 2 aborts the run
      ctrl_start = 1'b1; ctrl_op = 2'b01; opa = 32'h0000_00F0; opb = 32'h0000_0F00;
      @(negedge clock);
      ctrl_start = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("abort_busy", data_busy, 1'b0);
      chk("abort_rdy", data_resultRDY, 1'b0);
      chk("abort_result", data_result, 32'h0);
      chk("abort_zero", data_zero, 1'b0);
      rdy_cnt = 0;
      repeat (10) begin
         @(negedge clock);
         if (data_resultRDY) rdy_cnt++;
      end
      chk("abort_no_rdy", rdy_cnt, 0);
      do_op(2'b01, 32'h0000_00F0, 32'h0000_0F00, 1'b0, 1'b0);
      chk("fresh_edges", edges, 5);
      chk("fresh_result", data_result, 32'h0000_0FF0);
      @(negedge clock);

      // Reset dominates a simultaneous start
      reset = 1'b1; ctrl_start = 1'b1;
      @(negedge clock);
      chk("rst_dom_busy", data_busy, 1'b0);
      reset = 1'b0; ctrl_start = 1'b0;
      @(negedge clock);
      chk("rst_dom_idle", data_busy, 1'b0);

      // WIDTH=16, SLICE=16 sweep
      a16 = 16'($urandom); b16 = 16'($urandom);
      start16 = 1'b1; edges = 0; busy_cyc = 0;
      while (edges < 40) begin
         @(negedge clock);
         edges++;
         if (edges == 1) start16 = 1'b0;
         if (busy16) busy_cyc++;
         if (rdy16) break;
      end
      chk("w16_edges", edges, 2);
      chk("w16_busy", busy_cyc, 1);
      chk("w16_xor", res16, a16 ^ b16);

      // WIDTH=64, SLICE=4 sweep: XOR then NOR
      for (int k = 0; k < 2; k++) begin
         a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
         op64 = (k == 0) ? 2'b10 : 2'b11;
         start64 = 1'b1; edges = 0; busy_cyc = 0;
         while (edges < 60) begin
            @(negedge clock);
            edges++;
            if (edges == 1) start64 = 1'b0;
            if (busy64) busy_cyc++;
            if (rdy64) break;
         end
         chk("w64_edges", edges, 17);
         chk("w64_busy", busy_cyc, 16);
         chk(k == 0 ? "w64_xor" : "w64_nor", res64, (k == 0) ? (a64 ^ b64) : ~(a64 | b64));
         @(negedge clock);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_logic_unit.md
# multicycle_logic_unit

Parametrised, slice-serial bitwise logic unit for the MultDiv datapath. It generalises the single-cycle 32-bit AND to four selectable operations (AND, OR, XOR, NOR) over a configurable operand width. It processes SLICE bits per clock, LSB slice first. A start/ready handshake matches the mult/div units, so the same control logic can schedule all three.

## Interface
- WIDTH, 32: operand and result width in bits. Must be a multiple of SLICE.
- SLICE, 8: bits processed per clock. NSLICE = WIDTH/SLICE; legal range 1..WIDTH.
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high. Sampled on the rising edge of clock.
- ctrl_start  in  1  request a new operation. Sampled on each rising edge.
- ctrl_op  in  2  operation select, latched with the operands: 00 AND, 01 OR, 10 XOR, 11 NOR.
- data_operandA  in  WIDTH  operand A, latched on an accepted start.
- data_operandB  in  WIDTH  operand B, latched on an accepted start.
- data_result  out  WIDTH  completed result. Holds its value until the next completion.
- data_resultRDY  out  1  one-cycle pulse marking that data_result and data_zero are newly valid.
- data_busy  out  1  an operation is in progress; a new start is ignored while high.
- data_zero  out  1  the completed result is all zeros. Updated together with data_result.

## Operation
- The unit has two states, IDLE and RUN.
- In IDLE with ctrl_start=1, the rising edge does the following:
  - latch A, B and op into internal registers;
  - clear the slice counter;
  - clear the accumulator;
  - move to RUN and set data_busy=1.
- In RUN, each edge computes slice k: acc[k*SLICE +: SLICE] = op(A_slice, B_slice). The counter then increments.
- On the edge that computes slice NSLICE-1:
  - the complete value is written to data_result;
  - data_zero is set to (value == 0);
  - data_resultRDY=1 for the following cycle only;
  - data_busy=0 and the state returns to IDLE.
- ctrl_start while data_busy=1 is ignored. Nothing is queued, and the latched operands and op are unaffected.
- Input changes after acceptance have no effect on the running operation.
- NOR is ~(A|B) per bit, computed on the full slice width.
- An illegal WIDTH/SLICE combination is rejected at elaboration time.

## Timing
- Reset values:
  - data_result = 0
  - data_resultRDY = 0
  - data_busy = 0
  - data_zero = 0
  - state = IDLE
  - counter, accumulator and latched operands = 0
- Latency: a start accepted at edge E0 gives data_resultRDY=1 in the cycle after edge E0+NSLICE. With defaults (NSLICE=4), RDY is high after edge E0+4.
- data_busy is high from after E0 to after E0+NSLICE-1, which is NSLICE cycles. It is low in the RDY cycle.
- Back-to-back operation: ctrl_start held high during the RDY cycle is accepted at that edge, giving a throughput of one result per NSLICE+1 edges. data_result keeps the previous value until the new completion.
- If start is accepted on the same edge that drops RDY, RDY still falls to 0. No start is possible on the completion edge itself, because busy is still 1 at that edge.
- Reset while in RUN:
  - the operation is aborted;
  - all outputs return to their reset values on that edge;
  - no RDY pulse is produced.
- Reset dominates a simultaneous ctrl_start.
- SLICE=WIDTH (NSLICE=1): busy is high for one cycle and RDY follows after the second edge.
- data_result and data_zero change only on completion edges or on reset.

## Test plan
- Reset, then AND with A=0xF0F0_1234 and B=0xFF00_FFFF, start at E0:
  - busy is high for 4 cycles;
  - RDY pulses once after E0+4 with data_result=0xF000_1234 and data_zero=0.
- All four ops on A=0xAAAA_AAAA, B=0x5555_5555, run back-to-back with start held high:
  - the results, in order, are AND 0x0000_0000 (zero=1), OR 0xFFFF_FFFF, XOR 0xFFFF_FFFF and NOR 0x0000_0000 (zero=1);
  - RDY pulses every 5 edges.
- Busy-start rejection: start AND on A=B=0xFFFF_FFFF, then pulse start with op=OR and A=B=0 mid-run:
  - exactly one RDY pulse occurs, with result 0xFFFF_FFFF;
  - busy never extends beyond 4 cycles.
- Operand change: change A and B on the cycle after acceptance. The result reflects the originally latched values.
- Reset at the edge after acceptance + 2:
  - busy, RDY, data_result and data_zero are all 0 on the next cycle;
  - no RDY appears afterwards;
  - a fresh start then completes normally.
- Parameter sweep with WIDTH=16, SLICE=16 and with WIDTH=64, SLICE=4:
  - XOR on random operands matches the golden A^B;
  - RDY arrives after NSLICE+1 edges, i.e. 2 and 17 respectively.
